// File: rtl/mp_add_pkg.sv
// Shared types and constants for the multi-precision add/subtract controller.
package mp_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int LIMB_W     = 8;
    localparam int NBYTES_MIN = 2;
    localparam int NBYTES_MAX = 16;

endpackage

// File: rtl/mp_add_ctrl_if.sv
// Request/result bundle for mp_add_ctrl; op_sub exists only when MP_ADD_SUB_EN is defined.
interface mp_add_ctrl_if
    import mp_add_pkg::*;
#(
    parameter int NBYTES = 4
);
    logic                       start_valid;
    logic                       start_ready;
    logic [LIMB_W*NBYTES-1:0]   op_a;
    logic [LIMB_W*NBYTES-1:0]   op_b;
`ifdef MP_ADD_SUB_EN
    logic                       op_sub;
`endif
    logic                       res_valid;
    logic                       res_ready;
    logic [LIMB_W*NBYTES-1:0]   result;
    logic                       carry_out;
    logic                       overflow;
    logic                       busy;

    modport master (
        output start_valid, op_a, op_b, res_ready,
`ifdef MP_ADD_SUB_EN
        output op_sub,
`endif
        input  start_ready, res_valid, result, carry_out, overflow, busy
    );

    modport slave (
        input  start_valid, op_a, op_b, res_ready,
`ifdef MP_ADD_SUB_EN
        input  op_sub,
`endif
        output start_ready, res_valid, result, carry_out, overflow, busy
    );

endinterface

// File: rtl/addr_8bit.sv
// 8-bit ripple adder exposing the carries out of bit 6 and bit 7 for signed-overflow detection.
module addr_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       c6,
    output logic       c7
);
    logic [7:0] lo;
    logic [1:0] hi;

    assign lo = {1'b0, a[6:0]} + {1'b0, b[6:0]} + {7'b0, ci};
    assign c6 = lo[7];
    assign hi = {1'b0, a[7]} + {1'b0, b[7]} + {1'b0, c6};
    assign s  = {hi[0], lo[6:0]};
    assign c7 = hi[1];

endmodule

// File: rtl/mp_add_ctrl.sv
// Multi-precision adder: one 8-bit limb per cycle through a shared addr_8bit.
// Define MP_ADD_SUB_EN to add the op_sub port and a-b support.
//
// state | meaning
// IDLE  | ready for a new operation
// RUN   | processing limb idx_q, LSB limb first
// DONE  | result and flags held until res_ready
module mp_add_ctrl
    import mp_add_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    mp_add_ctrl_if.slave  bus
);
    localparam int W     = LIMB_W * NBYTES;
    localparam int IDX_W = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    if (NBYTES < NBYTES_MIN || NBYTES > NBYTES_MAX) begin : g_bad_nbytes
        $error("mp_add_ctrl: NBYTES out of range");
    end

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               carry_q, carry_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic [W-1:0]       result_q, result_d;
    logic               carry_out_q, carry_out_d;
    logic               overflow_q, overflow_d;
    logic               sub_mode;

`ifdef MP_ADD_SUB_EN
    logic               sub_q, sub_d;
    assign sub_mode = sub_q;
`else
    assign sub_mode = 1'b0;
`endif

    logic [LIMB_W-1:0]  limb_a, limb_b, limb_s;
    logic               c6, c7;

    assign limb_a = a_q[idx_q*LIMB_W +: LIMB_W];
    assign limb_b = b_q[idx_q*LIMB_W +: LIMB_W] ^ {LIMB_W{sub_mode}};

    addr_8bit u_addr (
        .a  (limb_a),
        .b  (limb_b),
        .ci (carry_q),
        .s  (limb_s),
        .c6 (c6),
        .c7 (c7)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        carry_d     = carry_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
`ifdef MP_ADD_SUB_EN
        sub_d       = sub_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.start_valid) begin
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                    idx_d   = '0;
`ifdef MP_ADD_SUB_EN
                    sub_d   = bus.op_sub;
                    carry_d = bus.op_sub;
`else
                    carry_d = 1'b0;
`endif
                    state_d = RUN;
                end
            end
            RUN: begin
                result_d[idx_q*LIMB_W +: LIMB_W] = limb_s;
                carry_d = c7;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST_IDX) begin
                    carry_out_d = c7;
                    overflow_d  = c6 ^ c7;
                    idx_d       = '0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
`ifdef MP_ADD_SUB_EN
            sub_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            carry_q     <= carry_d;
            a_q         <= a_d;
            b_q         <= b_d;
            result_q    <= result_d;
            carry_out_q <= carry_out_d;
            overflow_q  <= overflow_d;
`ifdef MP_ADD_SUB_EN
            sub_q       <= sub_d;
`endif
        end
    end

    assign bus.start_ready = (state_q == IDLE);
    assign bus.res_valid   = (state_q == DONE);
    assign bus.busy        = (state_q != IDLE);
    assign bus.result      = result_q;
    assign bus.carry_out   = carry_out_q;
    assign bus.overflow    = overflow_q;

endmodule

// File: doc/mp_add_ctrl.md
MP_ADD_CTRL -- requirements
Module: mp_add_ctrl

Interface
REQ-001 SHALL have parameter NBYTES, default 4, number of 8-bit limbs per operand (legal range 2..16).
REQ-002 SHALL have clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have start_valid  input  1  requester presents an operation.
REQ-005 SHALL have start_ready  output  1  controller can accept an operation.
REQ-006 SHALL have op_a, op_b  input  8*NBYTES each  operands, little-endian limbs.
REQ-007 SHALL have op_sub  input  1  subtract request; present only when MP_ADD_SUB_EN is defined.
REQ-008 SHALL have res_valid  output  1  result available.
REQ-009 SHALL have res_ready  input  1  consumer takes the result.
REQ-010 SHALL have result  output  8*NBYTES  sum or difference.
REQ-011 SHALL have carry_out and overflow  output  1 each  final-limb carry (c7) and signed overflow (c6 XOR c7).
REQ-012 SHALL have busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL time-share a single 8-bit adder, one limb per cycle, least significant limb first.
REQ-014 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-015 IDLE: start_ready=1; on start_valid, SHALL latch op_a/op_b (and op_sub), clear limb index, set carry register to 0 (1 for subtract), go RUN.
REQ-016 RUN: SHALL drive the adder with limb[idx] of a, of b (inverted for subtract), and carry-in from the carry register; write the sum to result limb idx; load carry register from c7; increment idx.
REQ-017 On the last limb (idx=NBYTES-1), SHALL capture carry_out=c7 and overflow=c6^c7, then go DONE.
REQ-018 Latency: res_valid SHALL rise exactly NBYTES cycles after the accepting edge.
REQ-019 DONE: res_valid=1; result, carry_out, and overflow SHALL hold stable until res_ready=1; on that edge go IDLE.
REQ-020 start_ready SHALL be 0 in RUN and DONE; start_valid there SHALL be ignored with no state change.
REQ-021 Throughput: SHALL be one operation per NBYTES+2 cycles minimum (no IDLE bypass).
REQ-022 result limbs not yet written in RUN SHALL retain the previous operation's value; only DONE values are architecturally defined.
REQ-023 Latched operands SHALL be unaffected by op_a/op_b changes after acceptance.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, idx=0, carry register=0, result=0, carry_out=0, overflow=0, res_valid=0, busy=0; start_ready SHALL read 1 once reset is released.
REQ-025 Reset asserted in RUN or DONE SHALL abort the operation with no res_valid produced.

Configuration
REQ-026 Macro MP_ADD_SUB_EN defined: op_sub port exists; subtract SHALL compute a-b via inverted b and initial carry 1; carry_out=1 SHALL mean no borrow.
REQ-027 Macro undefined: no op_sub port; the block SHALL add only; initial carry is always 0.

Structure
REQ-028 Package mp_add_pkg SHALL hold the FSM state enum (IDLE, RUN, DONE), the limb width constant (8), and the NBYTES legal-range limits.
REQ-029 SHALL instantiate the existing addr_8bit adder as its single sub-module (ports a, b, ci, s, c6, c7); no other arithmetic is permitted.

Verification (NBYTES=4)
REQ-030 a=FFFFFFFF, b=00000001 add -> result 00000000, carry_out 1, overflow 0, res_valid 4 cycles after accept.
REQ-031 a=7FFFFFFF, b=00000001 add -> result 80000000, carry_out 0, overflow 1.
REQ-032 a=55555555, b=AAAAAAAA add -> result FFFFFFFF, carry_out 0, overflow 0; second start_valid during RUN ignored (start_ready 0).
REQ-033 res_ready held low 5 cycles in DONE -> result and flags stable, start_ready 0; res_ready high -> IDLE next edge.
REQ-034 rst_n pulsed low during RUN limb 2 -> all outputs 0 immediately, IDLE, no res_valid; next operation completes correctly.
REQ-035 MP_ADD_SUB_EN: a=00000000, b=00000001 subtract -> result FFFFFFFF, carry_out 0, overflow 0; a=80000000, b=00000001 -> result 7FFFFFFF, overflow 1.
